ps2_key_decoder: RTL and testbench

- Sits between PS2_Controller and the game control/datapath.
- Consumes raw set-2 scan-code bytes (received_data / received_data_en) and tracks the prefix sequences F0 (break) and E0 (extended).
- Maps 8 game keys to key ids, keeps a debounced held-key vector, and pushes press/release events into a small FIFO.
- The game logic drains that FIFO with a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_event_fifo.sv | 48 ++++
 rtl/ps2_key_decoder.sv | 66 ++++++
 tb/tb_ps2_key_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, parser states and key map for the PS/2 key decoder
package ps2_pkg;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_Z = 8'h1A;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;
  localparam logic [7:0] SC_LEFT = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam int KEY_W = 3;
  // bit 0 = E0 seen, bit 1 = F0 seen
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXT = 2'b01;
  localparam logic [1:0] ST_BRK = 2'b10;
  localparam logic [1:0] ST_EXT_BRK = 2'b11;
  typedef struct packed {
    logic pressed;
    logic [KEY_W-1:0] key;
  } ps2_event_t;
  // returns {hit, key_id}; the E0 map and the plain map are disjoint
  function automatic logic [KEY_W:0] key_lookup(input logic [7:0] code, input logic ext);
    return ext ? (code == SC_UP ? {1'b1, 3'd4} :
                  code == SC_DOWN ? {1'b1, 3'd5} :
                  code == SC_LEFT ? {1'b1, 3'd6} :
                  code == SC_RIGHT ? {1'b1, 3'd7} : {1'b0, 3'd0})
               : (code == SC_Z ? {1'b1, 3'd0} :
                  code == SC_X ? {1'b1, 3'd1} :
                  code == SC_SPACE ? {1'b1, 3'd2} :
                  code == SC_ENTER ? {1'b1, 3'd3} : {1'b0, 3'd0});
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word fall-through FIFO
module ps2_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
  end
  // storage and pointers; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: set-2 scan-code parser producing held-key state and a press/release event queue
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_pressed,
  output logic [KEY_W-1:0] ev_key,
  output logic [7:0]       keys_held,
  output logic             overflow
);
  logic [1:0] st_q, st_d;
  logic [7:0] held_q, held_d;
  logic ovf_q, ovf_d;
  logic ext, brk, hit, was_held, push, full, empty;
  logic [KEY_W-1:0] id;
  ps2_event_t ev_in, ev_out;
  // prefix tracking, key decode and event generation; unmapped bytes only reset the parser
  always_comb begin
    ext = st_q[0];
    brk = st_q[1];
    {hit, id} = key_lookup(rx_data, ext);
    was_held = held_q[id];
    push = rx_valid && hit && (brk ? was_held : (!was_held || SUPPRESS_REPEAT == 0));
    held_d = held_q;
    if (rx_valid && hit) held_d[id] = !brk;
    st_d = !rx_valid ? st_q :
           rx_data == SC_EXT ? (brk ? ST_IDLE : ST_EXT) :
           rx_data == SC_BRK ? (brk ? ST_IDLE : {1'b1, ext}) : ST_IDLE;
    ev_in = '{pressed: !brk, key: id};
    ovf_d = ovf_q || (push && full && !(ev_ready && !empty));
  end
  // parser state, held-key vector and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_IDLE;
      held_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      held_q <= held_d;
      ovf_q <= ovf_d;
    end
  end
  ps2_event_fifo #(.WIDTH(KEY_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(ev_in),
    .full(full),
    .pop(ev_ready),
    .dout(ev_out),
    .empty(empty)
  );
  assign ev_valid = !empty;
  assign {ev_pressed, ev_key} = ev_out;
  assign keys_held = held_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven and scoreboard checks of the PS/2 key decoder
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic ev_ready = 1'b1;
  logic ev_valid, ev_pressed, overflow;
  logic [2:0] ev_key;
  logic [7:0] keys_held;
  logic r_ready = 1'b1;
  logic r_valid, r_pressed, r_overflow;
  logic [2:0] r_key;
  logic [7:0] r_held;
  int n_chk = 0;
  int n_fail = 0;
  int r_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [3:0] e;
    logic [7:0] held;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(4), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_pressed(ev_pressed),
    .ev_key(ev_key), .keys_held(keys_held), .overflow(overflow)
  );

  ps2_key_decoder #(.FIFO_DEPTH(4), .SUPPRESS_REPEAT(0)) dut_r (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_valid(r_valid), .ev_ready(r_ready), .ev_pressed(r_pressed),
    .ev_key(r_key), .keys_held(r_held), .overflow(r_overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every accepted head must match the oldest expected event
  always @(negedge clk) begin
    if (ev_valid && ev_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event", {28'd0, ev_pressed, ev_key}, 32'hFFFF);
      else chk("event", {28'd0, ev_pressed, ev_key}, {28'd0, exp_q.pop_front()});
    end
    if (r_valid) r_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    tbl.push_back('{8'h1A, 1'b1, 4'h8, 8'h01});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h01});
    tbl.push_back('{8'h1A, 1'b1, 4'h0, 8'h00});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h74, 1'b1, 4'hF, 8'h80});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h80});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h80});
    tbl.push_back('{8'h74, 1'b1, 4'h7, 8'h00});
    tbl.push_back('{8'h74, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h5A, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h5A, 1'b1, 4'hB, 8'h08});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h08});
    tbl.push_back('{8'h5A, 1'b1, 4'h3, 8'h00});
    tbl.push_back('{8'hE1, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h14, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h77, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hE1, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h14, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h77, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h6B, 1'b1, 4'hE, 8'h40});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h40});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h40});
    tbl.push_back('{8'h6B, 1'b1, 4'h6, 8'h00});
    tbl.push_back('{8'h22, 1'b1, 4'h9, 8'h02});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h02});
    tbl.push_back('{8'h22, 1'b1, 4'h1, 8'h00});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h00});
    tbl.push_back('{8'h75, 1'b1, 4'hC, 8'h10});
    tbl.push_back('{8'hE0, 1'b0, 4'h0, 8'h10});
    tbl.push_back('{8'hF0, 1'b0, 4'h0, 8'h10});
    tbl.push_back('{8'h75, 1'b1, 4'h4, 8'h00});

    idle(3);
    chk("rst_ev_valid", {31'd0, ev_valid}, 0);
    chk("rst_ev_pressed", {31'd0, ev_pressed}, 0);
    chk("rst_ev_key", {29'd0, ev_key}, 0);
    chk("rst_keys_held", {24'd0, keys_held}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    reset = 1'b0;
    ev_ready = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].ev) exp_q.push_back(tbl[i].e);
      send(tbl[i].b);
      chk($sformatf("held_vec%0d", i), {24'd0, keys_held}, {24'd0, tbl[i].held});
    end
    idle(4);
    chk("table_drained", exp_q.size(), 0);
    chk("table_overflow", {31'd0, overflow}, 0);

    r0 = r_cnt;
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h2);
    send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29);
    idle(4);
    chk("repeat_suppressed_drained", exp_q.size(), 0);
    chk("repeat_unsuppressed_events", r_cnt - r0, 4);
    chk("repeat_keys_held", {24'd0, keys_held}, 0);

    ev_ready = 1'b0;
    foreach (tbl[i]) if (0) ;
    exp_q.push_back(4'h8); send(8'h1A);
    exp_q.push_back(4'h9); send(8'h22);
    exp_q.push_back(4'hA); send(8'h29);
    exp_q.push_back(4'hB); send(8'h5A);
    chk("ovf_after4", {31'd0, overflow}, 0);
    send(8'hE0); send(8'h75);
    chk("ovf_after5", {31'd0, overflow}, 1);
    chk("ovf_ev_valid", {31'd0, ev_valid}, 1);
    chk("ovf_head_stable", {28'd0, ev_pressed, ev_key}, 32'h8);
    send(8'hE0); send(8'h72);
    chk("ovf_keys_held", {24'd0, keys_held}, 32'h3F);
    ev_ready = 1'b1;
    idle(6);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_empty", {31'd0, ev_valid}, 0);
    chk("ovf_sticky", {31'd0, overflow}, 1);

    pulse_reset();
    chk("reset_clears_ovf", {31'd0, overflow}, 0);
    ev_ready = 1'b0;
    exp_q.push_back(4'h8); send(8'h1A);
    exp_q.push_back(4'h9); send(8'h22);
    exp_q.push_back(4'hA); send(8'h29);
    exp_q.push_back(4'hB); send(8'h5A);
    send(8'hE0);
    exp_q.push_back(4'hC);
    @(posedge clk); #1;
    rx_data = 8'h75;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    chk("fullpop_overflow", {31'd0, overflow}, 0);
    chk("fullpop_valid", {31'd0, ev_valid}, 1);
    chk("fullpop_head", {28'd0, ev_pressed, ev_key}, 32'h9);
    chk("fullpop_held", {24'd0, keys_held}, 32'h1F);
    ev_ready = 1'b1;
    idle(6);
    chk("fullpop_drained", exp_q.size(), 0);
    chk("fullpop_empty", {31'd0, ev_valid}, 0);

    send(8'hE0);
    send(8'hF0);
    pulse_reset();
    send(8'h75);
    chk("abort_no_event", {31'd0, ev_valid}, 0);
    chk("abort_keys_held", {24'd0, keys_held}, 0);
    exp_q.push_back(4'h8);
    send(8'h1A);
    chk("abort_idle_latency", {31'd0, ev_valid}, 1);
    chk("abort_idle_held", {24'd0, keys_held}, 32'h01);
    idle(4);
    chk("abort_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
